// File: rtl/raymarch_pixel_scheduler.sv
// Raster-order pixel scheduler between frame control, the raymarcher and the framebuffer write port.
// Optional per-pixel WAIT timeout enabled by defining RM_TIMEOUT_EN.
module raymarch_pixel_scheduler #(
  parameter int unsigned WIDTH          = 300,
  parameter int unsigned HEIGHT         = 300,
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [23:0] TIMEOUT_COLOR  = 24'hFF00FF
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic              abort_in,
  output logic [15:0]       curr_x,
  output logic [15:0]       curr_y,
  output logic              pixel_start_out,
  input  logic              pixel_done_in,
  input  logic [7:0]        red_in,
  input  logic [7:0]        green_in,
  input  logic [7:0]        blue_in,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [23:0]       fb_data_out,
  output logic              fb_we_out,
  input  logic              fb_ready_in,
  output logic              busy_out,
  output logic              frame_done_out
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  // Elaboration-time sanity check of the frame geometry and timeout setup.
  if ((WIDTH < 1) || (HEIGHT < 1) || (WIDTH > 65536) || (HEIGHT > 65536) ||
      (TIMEOUT_CYCLES < 1) ||
      ((64'(1) << ADDR_W) < (64'(WIDTH) * 64'(HEIGHT)))) begin : g_bad_cfg
    $error("raymarch_pixel_scheduler: bad configuration (timeout colour %h)", TIMEOUT_COLOR);
  end

  state_t            state, state_d;
  logic [15:0]       x_d, y_d;
  logic [ADDR_W-1:0] addr_d;
  logic [23:0]       data_d;
  logic              last_x, last_y, tmo_hit;

  assign last_x = (curr_x == 16'(WIDTH - 1));
  assign last_y = (curr_y == 16'(HEIGHT - 1));

`ifdef RM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign tmo_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in WAIT; zero on every entry into WAIT.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in)                wait_cnt <= '0;
    else if (state != S_WAIT)  wait_cnt <= '0;
    else                       wait_cnt <= wait_cnt + CNT_W'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and datapath update; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state;
    x_d     = curr_x;
    y_d     = curr_y;
    addr_d  = fb_addr_out;
    data_d  = fb_data_out;
    case (state)
      S_IDLE: begin
        if (frame_start_in) begin
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (pixel_done_in) begin
          data_d  = {red_in, green_in, blue_in};
          state_d = S_WRITE;
        end else if (tmo_hit) begin
          data_d  = TIMEOUT_COLOR;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (fb_ready_in) begin
          if (last_x && last_y) begin
            state_d = S_DONE;
          end else begin
            addr_d  = fb_addr_out + ADDR_W'(1);
            state_d = S_ISSUE;
            if (last_x) begin
              x_d = '0;
              y_d = curr_y + 16'd1;
            end else begin
              x_d = curr_x + 16'd1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_in && (state != S_IDLE)) begin
      state_d = S_IDLE;
      x_d     = curr_x;
      y_d     = curr_y;
      addr_d  = fb_addr_out;
      data_d  = fb_data_out;
    end
  end

  // State and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      curr_x          <= '0;
      curr_y          <= '0;
      fb_addr_out     <= '0;
      fb_data_out     <= '0;
      pixel_start_out <= 1'b0;
      fb_we_out       <= 1'b0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
    end else begin
      state           <= state_d;
      curr_x          <= x_d;
      curr_y          <= y_d;
      fb_addr_out     <= addr_d;
      fb_data_out     <= data_d;
      pixel_start_out <= (state_d == S_ISSUE);
      fb_we_out       <= (state_d == S_WRITE);
      busy_out        <= (state_d != S_IDLE);
      frame_done_out  <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_raymarch_pixel_scheduler.sv
// Directed bench for raymarch_pixel_scheduler on a 2x2 frame; timeout scenario runs when RM_TIMEOUT_EN is defined.
module tb_raymarch_pixel_scheduler;

  localparam int unsigned W = 2;
  localparam int unsigned H = 2;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          abort = 1'b0;
  logic          fb_ready = 1'b1;
  logic          done_resp = 1'b0;
  logic          done_inj = 1'b0;
  logic          pixel_done;
  logic [7:0]    red = 8'd0, green = 8'd0, blue = 8'd0;
  logic          skip_px1 = 1'b0;
  logic [15:0]   curr_x, curr_y;
  logic          pixel_start_out, fb_we_out, busy_out, frame_done_out;
  logic [AW-1:0] fb_addr_out;
  logic [23:0]   fb_data_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fdone_cnt = 0;
  int st_x[$], st_y[$], st_cyc[$], wr_addr[$], wr_cyc[$];
  logic [23:0] wr_data[$];

  assign pixel_done = done_resp | done_inj;

  always #5 clk = ~clk;

  raymarch_pixel_scheduler #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT_CYCLES(8), .TIMEOUT_COLOR(24'hFF00FF)
  ) dut (
    .clk_pixel_in(clk), .rst_in(rst), .frame_start_in(frame_start), .abort_in(abort),
    .curr_x(curr_x), .curr_y(curr_y), .pixel_start_out(pixel_start_out),
    .pixel_done_in(pixel_done), .red_in(red), .green_in(green), .blue_in(blue),
    .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out), .fb_we_out(fb_we_out),
    .fb_ready_in(fb_ready), .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  // Logs issues, accepted writes and frame-done pulses as seen at each edge.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (pixel_start_out) begin
        st_x.push_back(int'(curr_x)); st_y.push_back(int'(curr_y)); st_cyc.push_back(cyc);
      end
      if (fb_we_out && fb_ready) begin
        wr_addr.push_back(int'(fb_addr_out)); wr_data.push_back(fb_data_out); wr_cyc.push_back(cyc);
      end
      if (frame_done_out) fdone_cnt++;
    end
  end

  // Raymarcher stand-in: answers 3 cycles after each start with rgb = 10*(pixel index + 1).
  int pend = 0;
  always @(negedge clk) begin
    int n;
    done_resp = 1'b0;
    if (rst) pend = 0;
    else begin
      if (pend == 1) begin
        n = int'(curr_y) * int'(W) + int'(curr_x) + 1;
        red = 8'(10 * n); green = 8'(10 * n); blue = 8'(10 * n);
        done_resp = 1'b1;
        pend = 0;
      end else if (pend > 1) pend--;
      if (pixel_start_out && !(skip_px1 && curr_x == 16'd1 && curr_y == 16'd0)) pend = 3;
    end
  end

  task automatic start_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic run_until_done(input int base_f, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (fdone_cnt > base_f) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 8;
    if (curr_x !== 16'd0)       begin miscompares++; $display("FAIL reset_x: got %h expected 0", curr_x); end
    if (curr_y !== 16'd0)       begin miscompares++; $display("FAIL reset_y: got %h expected 0", curr_y); end
    if (fb_addr_out !== 2'd0)   begin miscompares++; $display("FAIL reset_addr: got %h expected 0", fb_addr_out); end
    if (fb_data_out !== 24'd0)  begin miscompares++; $display("FAIL reset_data: got %h expected 0", fb_data_out); end
    if (pixel_start_out !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b expected 0", pixel_start_out); end
    if (fb_we_out !== 1'b0)     begin miscompares++; $display("FAIL reset_we: got %b expected 0", fb_we_out); end
    if (busy_out !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    if (frame_done_out !== 1'b0) begin miscompares++; $display("FAIL reset_fdone: got %b expected 0", frame_done_out); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset: busy %b expected 0", busy_out); end
  endtask

  task automatic test_frame();
    int bs = st_x.size(), bw = wr_addr.size(), bf = fdone_cnt;
    bit ok;
    start_frame();
    run_until_done(bf, 100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL frame_timeout: frame_done not seen in 100 cycles"); end
    vectors += 3;
    if (st_x.size() - bs !== 4) begin miscompares++; $display("FAIL frame_issues: got %0d expected 4", st_x.size() - bs); end
    if (wr_addr.size() - bw !== 4) begin miscompares++; $display("FAIL frame_writes: got %0d expected 4", wr_addr.size() - bw); end
    if (fdone_cnt - bf !== 1) begin miscompares++; $display("FAIL frame_done_count: got %0d expected 1", fdone_cnt - bf); end
    if (st_x.size() - bs == 4 && wr_addr.size() - bw == 4) begin
      for (int i = 0; i < 4; i++) begin
        vectors += 4;
        if (st_x[bs+i] !== i % 2) begin miscompares++; $display("FAIL frame_x[%0d]: got %0d expected %0d", i, st_x[bs+i], i % 2); end
        if (st_y[bs+i] !== i / 2) begin miscompares++; $display("FAIL frame_y[%0d]: got %0d expected %0d", i, st_y[bs+i], i / 2); end
        if (wr_addr[bw+i] !== i) begin miscompares++; $display("FAIL frame_addr[%0d]: got %0d expected %0d", i, wr_addr[bw+i], i); end
        if (wr_data[bw+i] !== {3{8'(10 * (i + 1))}}) begin
          miscompares++; $display("FAIL frame_data[%0d]: got %h expected %h", i, wr_data[bw+i], {3{8'(10 * (i + 1))}});
        end
      end
      vectors++;
      if (wr_cyc[bw] - st_cyc[bs] !== 4) begin miscompares++; $display("FAIL pixel_latency: got %0d expected 4", wr_cyc[bw] - st_cyc[bs]); end
    end
    vectors += 2;
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL frame_busy_after: got %b expected 0", busy_out); end
    if (frame_done_out !== 1'b0) begin miscompares++; $display("FAIL frame_done_width: got %b expected 0", frame_done_out); end
  endtask

  task automatic test_backpressure();
    int bs = st_x.size(), bw = wr_addr.size(), bf = fdone_cnt;
    bit ok = 1'b0;
    fb_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 20 && !ok; i++) begin
      if (fb_we_out) ok = 1'b1; else @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_no_we: fb_we_out not seen in 20 cycles"); end
    for (int i = 0; i < 5; i++) begin
      vectors += 4;
      if (fb_we_out !== 1'b1) begin miscompares++; $display("FAIL bp_we[%0d]: got %b expected 1", i, fb_we_out); end
      if (fb_addr_out !== 2'd0) begin miscompares++; $display("FAIL bp_addr[%0d]: got %h expected 0", i, fb_addr_out); end
      if (fb_data_out !== 24'h0A0A0A) begin miscompares++; $display("FAIL bp_data[%0d]: got %h expected 0a0a0a", i, fb_data_out); end
      if (st_x.size() - bs !== 1) begin miscompares++; $display("FAIL bp_issues[%0d]: got %0d expected 1", i, st_x.size() - bs); end
      @(negedge clk);
    end
    fb_ready = 1'b1;
    run_until_done(bf, 100, ok);
    vectors += 3;
    if (!ok) begin miscompares++; $display("FAIL bp_timeout: frame_done not seen"); end
    if (wr_addr.size() - bw !== 4) begin miscompares++; $display("FAIL bp_writes: got %0d expected 4", wr_addr.size() - bw); end
    if (wr_addr.size() - bw == 4 && wr_addr[bw+3] !== 3) begin
      miscompares++; $display("FAIL bp_last_addr: got %0d expected 3", wr_addr[bw+3]);
    end
  endtask

  task automatic test_ignored_inputs();
    int bs = st_x.size(), bw = wr_addr.size(), bf = fdone_cnt;
    bit ok = 1'b0;
    @(negedge clk) frame_start = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      done_inj = pixel_start_out | fb_we_out;
      if (frame_done_out) frame_start = 1'b0;
      if (fdone_cnt > bf) ok = 1'b1;
    end
    done_inj = 1'b0;
    frame_start = 1'b0;
    vectors += 4;
    if (!ok) begin miscompares++; $display("FAIL ign_timeout: frame_done not seen"); end
    if (st_x.size() - bs !== 4) begin miscompares++; $display("FAIL ign_issues: got %0d expected 4", st_x.size() - bs); end
    if (wr_addr.size() - bw !== 4) begin miscompares++; $display("FAIL ign_writes: got %0d expected 4", wr_addr.size() - bw); end
    if (fdone_cnt - bf !== 1) begin miscompares++; $display("FAIL ign_fdone: got %0d expected 1", fdone_cnt - bf); end
    if (wr_addr.size() - bw == 4 && st_x.size() - bs == 4) begin
      for (int i = 0; i < 4; i++) begin
        vectors += 3;
        if (wr_addr[bw+i] !== i) begin miscompares++; $display("FAIL ign_addr[%0d]: got %0d expected %0d", i, wr_addr[bw+i], i); end
        if (wr_data[bw+i] !== {3{8'(10 * (i + 1))}}) begin
          miscompares++; $display("FAIL ign_data[%0d]: got %h expected %h", i, wr_data[bw+i], {3{8'(10 * (i + 1))}});
        end
        if (st_x[bs+i] + 2 * st_y[bs+i] !== i) begin miscompares++; $display("FAIL ign_coord[%0d]: got %0d,%0d", i, st_x[bs+i], st_y[bs+i]); end
      end
    end
    repeat (3) @(negedge clk);
    vectors += 2;
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL ign_restart: busy %b expected 0", busy_out); end
    if (st_x.size() - bs !== 4) begin miscompares++; $display("FAIL ign_extra_issue: got %0d expected 4", st_x.size() - bs); end
  endtask

  task automatic test_abort();
    int bf = fdone_cnt, bw;
    bit ok = 1'b0;
    start_frame();
    for (int i = 0; i < 50 && !ok; i++) begin
      if (fb_we_out && fb_addr_out == 2'd1) ok = 1'b1; else @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL abort_no_write1: write of pixel 1 not seen"); end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    vectors += 6;
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy_out); end
    if (fb_we_out !== 1'b0) begin miscompares++; $display("FAIL abort_we: got %b expected 0", fb_we_out); end
    if (pixel_start_out !== 1'b0) begin miscompares++; $display("FAIL abort_start: got %b expected 0", pixel_start_out); end
    if (curr_x !== 16'd1) begin miscompares++; $display("FAIL abort_x_held: got %0d expected 1", curr_x); end
    if (curr_y !== 16'd0) begin miscompares++; $display("FAIL abort_y_held: got %0d expected 0", curr_y); end
    if (fb_addr_out !== 2'd1) begin miscompares++; $display("FAIL abort_addr_held: got %0d expected 1", fb_addr_out); end
    repeat (5) @(negedge clk);
    vectors += 2;
    if (fdone_cnt !== bf) begin miscompares++; $display("FAIL abort_fdone: got %0d expected %0d", fdone_cnt, bf); end
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle: busy %b expected 0", busy_out); end
    bw = wr_addr.size();
    start_frame();
    vectors += 3;
    if (pixel_start_out !== 1'b1) begin miscompares++; $display("FAIL restart_start: got %b expected 1", pixel_start_out); end
    if (curr_x !== 16'd0) begin miscompares++; $display("FAIL restart_x: got %0d expected 0", curr_x); end
    if (curr_y !== 16'd0) begin miscompares++; $display("FAIL restart_y: got %0d expected 0", curr_y); end
    run_until_done(bf, 100, ok);
    vectors += 2;
    if (wr_addr.size() - bw !== 4) begin miscompares++; $display("FAIL restart_writes: got %0d expected 4", wr_addr.size() - bw); end
    if (wr_addr.size() > bw && wr_addr[bw] !== 0) begin miscompares++; $display("FAIL restart_addr0: got %0d expected 0", wr_addr[bw]); end
    else if (wr_addr.size() <= bw) begin miscompares++; $display("FAIL restart_addr0: no write seen, expected addr 0"); end
  endtask

  task automatic test_reset_mid_frame();
    int bs, bw;
    bit ok = 1'b0;
    start_frame();
    for (int i = 0; i < 50 && !ok; i++) begin
      if (pixel_start_out && curr_y == 16'd1) ok = 1'b1; else @(negedge clk);
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rstmid_no_row1: issue of row 1 not seen"); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors += 7;
    if (curr_x !== 16'd0) begin miscompares++; $display("FAIL rstmid_x: got %0d expected 0", curr_x); end
    if (curr_y !== 16'd0) begin miscompares++; $display("FAIL rstmid_y: got %0d expected 0", curr_y); end
    if (fb_addr_out !== 2'd0) begin miscompares++; $display("FAIL rstmid_addr: got %0d expected 0", fb_addr_out); end
    if (fb_data_out !== 24'd0) begin miscompares++; $display("FAIL rstmid_data: got %h expected 0", fb_data_out); end
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy_out); end
    if (fb_we_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_we: got %b expected 0", fb_we_out); end
    if (pixel_start_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_start: got %b expected 0", pixel_start_out); end
    @(negedge clk) rst = 1'b0;
    bs = st_x.size();
    bw = wr_addr.size();
    repeat (20) @(negedge clk);
    vectors += 3;
    if (wr_addr.size() !== bw) begin miscompares++; $display("FAIL rstmid_writes: got %0d expected 0", wr_addr.size() - bw); end
    if (st_x.size() !== bs) begin miscompares++; $display("FAIL rstmid_issues: got %0d expected 0", st_x.size() - bs); end
    if (busy_out !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: busy %b expected 0", busy_out); end
  endtask

`ifdef RM_TIMEOUT_EN
  task automatic test_timeout();
    int bs = st_x.size(), bw = wr_addr.size(), bf = fdone_cnt;
    bit ok;
    skip_px1 = 1'b1;
    start_frame();
    run_until_done(bf, 200, ok);
    skip_px1 = 1'b0;
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL tmo_frame: frame_done not seen"); end
    if (wr_addr.size() - bw !== 4) begin miscompares++; $display("FAIL tmo_writes: got %0d expected 4", wr_addr.size() - bw); end
    if (wr_addr.size() - bw == 4 && st_x.size() - bs == 4) begin
      vectors += 5;
      if (wr_addr[bw+1] !== 1) begin miscompares++; $display("FAIL tmo_addr: got %0d expected 1", wr_addr[bw+1]); end
      if (wr_data[bw+1] !== 24'hFF00FF) begin miscompares++; $display("FAIL tmo_color: got %h expected ff00ff", wr_data[bw+1]); end
      if (wr_cyc[bw+1] - st_cyc[bs+1] !== 9) begin miscompares++; $display("FAIL tmo_delay: got %0d expected 9", wr_cyc[bw+1] - st_cyc[bs+1]); end
      if (wr_data[bw+2] !== 24'h1E1E1E) begin miscompares++; $display("FAIL tmo_next_data: got %h expected 1e1e1e", wr_data[bw+2]); end
      if (wr_data[bw+3] !== 24'h282828) begin miscompares++; $display("FAIL tmo_last_data: got %h expected 282828", wr_data[bw+3]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_ignored_inputs();
    test_abort();
    test_reset_mid_frame();
`ifdef RM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
